fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch front end for the 5-stage LEGv8 pipeline; feeds the IF/ID pipeline register (`{pc, instr}`).
- Owns the fetch PC and issues in-order requests to a variable-latency instruction memory (valid/ready request, valid-only response).
- Buffers returned instructions in a DEPTH-entry prefetch FIFO.
- Presents them to decode with valid/ready; flushes on branch redirect from MEM (taken branch: `branch & zero`, target = branch adder result).

Parameters:
- ADDR_W, 64, PC / address width
- INSTR_W, 32, instruction width
- DEPTH, 4, prefetch FIFO entries; also the max outstanding requests (power of two, >=2)
- RESET_PC, 64'h0, first fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- pc_reset_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  fetch address
- imem_resp_valid  in  1  in-order response valid (no backpressure)
- imem_resp_data  in  INSTR_W  returned instruction
- redirect_valid  in  1  taken branch; flush and refetch
- redirect_pc  in  ADDR_W  branch target
- out_valid  out  1  instruction available to IF/ID
- out_ready  in  1  IF/ID accepts (low = stall)
- out_pc  out  ADDR_W  PC of out_instr
- out_instr  out  INSTR_W  instruction

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, pend=0, drop=0; out_valid=0, imem_req_valid=0. First cycle after release: imem_req_valid=1, addr=RESET_PC.
- Counters: `pend` = requests accepted and not yet responded (includes those to be dropped); `drop` = responses still to discard; `count` = FIFO occupancy. Counter width is clog2(DEPTH+1).
- Issue: imem_req_valid = !redirect_valid && (count + pend < DEPTH). The credit check is conservative, so the FIFO never overflows.
  - On req handshake: fetch_pc += 4 (mod 2^ADDR_W, wraps silently), pend++.
- Response: every imem_resp_valid decrements pend.
  - If drop>0: drop--, data discarded.
  - Otherwise push {resp_pc, data}, then resp_pc += 4.
  - A response arriving with pend==0 is a protocol error: ignored, no state change.
- Output: out_valid = (count>0) && !redirect_valid; out_pc/out_instr = FIFO head.
  - Pop on out_valid && out_ready.
  - Output is held stable while out_valid && !out_ready.
- Latency: response to out_valid is 1 cycle minimum (registered FIFO, no bypass). Steady-state throughput is 1 instr/cycle with a 1-cycle memory.
- Same-cycle push and pop: both occur, count unchanged. Full FIFO with pop and push in the same cycle is legal.
- Redirect (priority over everything that cycle):
  - FIFO cleared, no pop, no request issued.
  - fetch_pc <= redirect_pc; resp_pc <= redirect_pc.
  - drop <= pend (minus 1 if a response also arrives this cycle, since that response is itself discarded); pend updated normally.
  - Next cycle: request at redirect_pc if credit allows.
  - Back-to-back redirects: the last one wins; drop is recomputed each time.
- Reset mid-operation: immediate return to reset state. Responses arriving after reset with pend==0 are ignored per the rule above.
- The address low two bits are not checked (word-aligned by construction).

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_flush_cnt (32) and perf_starve_cnt (32), reset to 0, saturating at all-ones.
  - perf_flush_cnt: +1 per redirect cycle.
  - perf_starve_cnt: +1 per cycle with out_ready=1, out_valid=0, no redirect.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg: ADDR_W/INSTR_W defaults, INSTR_BYTES=4, fetch_entry_t struct {pc, instr}.
- Natural sub-module: fetch_fifo (DEPTH-entry sync FIFO: push, pop, flush, count, head; flush dominates push).

Test Plan:
- Release reset, 1-cycle memory, out_ready=1 → requests 0x0,0x4,0x8,0xC…; outputs pc 0x0,0x4,0x8 with matching instrs, out_valid from cycle 3 onward every cycle.
- out_ready=0 for 10 cycles → FIFO fills to 4; imem_req_valid drops to 0 once count+pend=4; out_pc held at 0x0; on release, 0x0..0xC drain in order.
- 3-cycle memory, 2 requests (0x10,0x14) in flight, redirect_pc=0x100 → both responses discarded; next output pc=0x100; no 0x10/0x14 seen.
- Redirect in the same cycle as a response and out_ready=1 → no pop that cycle, response dropped, drop=pend-1; next output pc=redirect_pc.
- fetch_pc=64'hFFFF_FFFF_FFFF_FFFC → next request address 0x0; out_pc wraps identically.
- Assert pc_reset_n low with FIFO holding 3 entries → out_valid=0 and imem_req_valid=0 immediately; after release, first request at RESET_PC.
- With FETCH_PERF_EN, the above sequences yield exact perf_flush_cnt / perf_starve_cnt values.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and entry type for the fetch stage
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 64;
  localparam int FETCH_INSTR_W = 32;
  localparam int INSTR_BYTES   = 4;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous prefetch FIFO; flush dominates push and pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = FETCH_ADDR_W + FETCH_INSTR_W,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  // Callers never pop when empty nor push when full without a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 fetch front end: PC, imem requests, prefetch FIFO, redirect flush
// Optional macro FETCH_PERF_EN adds perf_flush_cnt / perf_starve_cnt outputs.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
  input  logic               clk,
  input  logic               pc_reset_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_flush_cnt,
  output logic [31:0]        perf_starve_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

  logic [ADDR_W-1:0]         r_fetch_pc;
  logic [ADDR_W-1:0]         r_resp_pc;
  logic [CW-1:0]             r_pend;
  logic [CW-1:0]             r_drop;
  logic [CW-1:0]             w_count;
  logic [ADDR_W+INSTR_W-1:0] w_head;
  logic                      w_credit;
  logic                      w_req_fire;
  logic                      w_resp;
  logic                      w_push;
  logic                      w_pop;

  // Credits cover both buffered and in-flight entries, so the FIFO cannot overflow.
  assign w_credit       = ({1'b0, w_count} + {1'b0, r_pend}) < SW'(DEPTH);
  assign imem_req_valid = pc_reset_n && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_resp         = imem_resp_valid && (r_pend != '0);
  assign w_push         = w_resp && (r_drop == '0) && !redirect_valid;
  assign out_valid      = (w_count != '0) && !redirect_valid;
  assign w_pop          = out_valid && out_ready;
  assign out_pc         = w_head[ADDR_W+INSTR_W-1:INSTR_W];
  assign out_instr      = w_head[INSTR_W-1:0];

  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_pend     <= '0;
      r_drop     <= '0;
    end else begin
      r_pend <= r_pend + CW'(w_req_fire) - CW'(w_resp);
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_resp_pc  <= redirect_pc;
        r_drop     <= r_pend - CW'(w_resp);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + STEP;
        if (w_push)     r_resp_pc  <= r_resp_pc + STEP;
        if (w_resp && (r_drop != '0)) r_drop <= r_drop - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .W     (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (pc_reset_n),
    .i_push  (w_push),
    .i_data  ({r_resp_pc, imem_resp_data}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_count (w_count),
    .o_head  (w_head)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_flush_cnt;
  logic [31:0] r_starve_cnt;

  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      r_flush_cnt  <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (redirect_valid && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (out_ready && !out_valid && !redirect_valid && (r_starve_cnt != '1))
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign perf_flush_cnt  = r_flush_cnt;
  assign perf_starve_cnt = r_starve_cnt;
`endif

endmodule
